player_mover: RTL and testbench
===============================

PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 Parameter COLS, default 5, number of grid columns (2..16).
REQ-002 Parameter ROWS, default 5, number of grid rows (2..16).
REQ-003 Parameter CELL, default 16, cell pitch in pixels.
REQ-004 Parameter X0, default 40, pixel x of column 0; Y0, default 20, pixel y of row 0.
REQ-005 Parameter START_COL, default 2, and START_ROW, default 2, set the reset cell.
REQ-006 Parameter STEP_PX, default 4, pixels advanced per tick while moving; CELL SHALL be a multiple of STEP_PX.
REQ-007 Parameter REPEAT_DELAY, default 8, and REPEAT_RATE, default 4, are the auto-repeat intervals in ticks.
REQ-008 Parameter X_W, default 8, and Y_W, default 7, set the pixel output widths.
REQ-009 clk  input  1  clock.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 tick  input  1  frame-rate enable; all movement and repeat timing advances only on clk edges with tick=1.
REQ-012 enable  input  1  when 0, new move requests are ignored.
REQ-013 up, down, left, right  input  1 each  level direction requests.
REQ-014 x  output  X_W  current pixel x.
REQ-015 y  output  Y_W  current pixel y.
REQ-016 col  output  clog2(COLS)  committed target column; row  output  clog2(ROWS)  committed target row.
REQ-017 moving  output  1  high while x/y lag the committed cell.
REQ-018 bump  output  1  one-clk pulse when a request is refused at a grid edge.

Function
REQ-019 Direction decode: up+down together cancel the vertical axis; left+right together cancel the horizontal axis; remaining priority SHALL be up > down > left > right; no surviving direction = NONE.
REQ-020 The decoded direction SHALL be sampled only on tick; dir_prev holds the previous sampled value.
REQ-021 A request SHALL fire on a tick when dir != NONE and dir != dir_prev (new press).
REQ-022 While dir == dir_prev != NONE, a hold counter SHALL increment per tick; a request fires when the counter reaches REPEAT_DELAY, after which the counter reloads to REPEAT_DELAY-REPEAT_RATE, giving a repeat every REPEAT_RATE ticks.
REQ-023 The hold counter SHALL clear to 0 on a direction change or on NONE.
REQ-024 FSM states: IDLE, MOVE.
REQ-025 In IDLE, a fired request with enable=1 whose target cell lies inside 0..COLS-1 / 0..ROWS-1 SHALL update col/row, set moving=1 and enter MOVE on the same edge.
REQ-026 In IDLE, a fired request whose target lies outside the grid SHALL leave col/row unchanged and pulse bump for exactly one clk.
REQ-027 In MOVE, each tick SHALL move x or y by STEP_PX toward X0+col*CELL / Y0+row*CELL; when the target is reached on that edge, the block SHALL return to IDLE with moving=0 on the same edge.
REQ-028 Requests fired in MOVE or with enable=0 SHALL be dropped (not queued), and SHALL not pulse bump; the hold counter keeps running.
REQ-029 enable=0 during MOVE SHALL NOT abort the move in progress.
REQ-030 A single step SHALL take exactly CELL/STEP_PX ticks.
REQ-031 The arithmetic SHALL be free of overflow for any X0+(COLS-1)*CELL < 2^X_W and Y0+(ROWS-1)*CELL < 2^Y_W.

Reset
REQ-032 On reset, col=START_COL, row=START_ROW, x=X0+START_COL*CELL, y=Y0+START_ROW*CELL, moving=0, bump=0, state=IDLE, dir_prev=NONE, hold counter=0.
REQ-033 Reset asserted mid-move SHALL discard the move and restore the REQ-032 values immediately.

Verification
REQ-034 Reset with defaults -> x=72, y=52, col=2, row=2, moving=0.
REQ-035 right held for 1 tick, then released -> col=3, moving=1; x=76,80,84,88 on the next 4 ticks; moving=0 on the tick where x reaches 88.
REQ-036 up held continuously from row 2 -> steps fire at ticks 0 and 8 (row 1, then row 0); at tick 12 the target is row -1, so bump pulses once, row=0 and y=20.
REQ-037 left+right+down held together -> only down acts: row 2->3, y 52->68, x unchanged.
REQ-038 A new right press on tick 2 of a move -> dropped; the move completes at x=88 and col stays 3.
REQ-039 Reset asserted while x=80 mid-move -> x=72, col=2, moving=0 asynchronously.

Source files
------------

// File: rtl/player_mover_if.sv
// Handshake bundle between the game logic and the grid-locked player mover.
// Widths must match the player_mover instance parameters.
interface player_mover_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int COL_W = 3,
    parameter int ROW_W = 3
);
    logic             tick;
    logic             enable;
    logic             up;
    logic             down;
    logic             left;
    logic             right;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             moving;
    logic             bump;

    modport master (
        output tick, enable, up, down, left, right,
        input  x, y, col, row, moving, bump
    );

    modport slave (
        input  tick, enable, up, down, left, right,
        output x, y, col, row, moving, bump
    );
endinterface

// File: rtl/player_mover.sv
// Grid-locked player mover: decodes direction levels with auto-repeat, commits
// a target cell, then glides the pixel position toward it STEP_PX per tick.
module player_mover #(
    parameter int COLS         = 5,
    parameter int ROWS         = 5,
    parameter int CELL         = 16,
    parameter int X0           = 40,
    parameter int Y0           = 20,
    parameter int START_COL    = 2,
    parameter int START_ROW    = 2,
    parameter int STEP_PX      = 4,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4,
    parameter int X_W          = 8,
    parameter int Y_W          = 7
) (
    input  logic          clk,
    input  logic          reset,
    player_mover_if.slave bus
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int HC_W  = $clog2(REPEAT_DELAY + 1);

    localparam logic [X_W-1:0]   X_RST   = X_W'(X0 + START_COL * CELL);
    localparam logic [Y_W-1:0]   Y_RST   = Y_W'(Y0 + START_ROW * CELL);
    localparam logic [COL_W-1:0] COL_RST = COL_W'(START_COL);
    localparam logic [ROW_W-1:0] ROW_RST = ROW_W'(START_ROW);
    localparam logic [X_W-1:0]   STEP_X  = X_W'(STEP_PX);
    localparam logic [Y_W-1:0]   STEP_Y  = Y_W'(STEP_PX);

    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic {IDLE, MOVE} state_t;

    state_t           state, state_d;
    dir_t             dir, dir_prev;
    logic [HC_W-1:0]  hold_cnt, hold_nxt;
    logic             fire;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [X_W-1:0]   x_q, x_step, tx;
    logic [Y_W-1:0]   y_q, y_step, ty;
    logic             bump_q;
    int               t_col, t_row;
    logic             in_grid, arrive;
    logic             accept, do_bump, advance;

    // Opposing requests cancel their axis before priority is applied.
    always_comb begin
        dir = DIR_NONE;
        if (bus.up && !bus.down)         dir = DIR_UP;
        else if (bus.down && !bus.up)    dir = DIR_DOWN;
        else if (bus.left && !bus.right) dir = DIR_LEFT;
        else if (bus.right && !bus.left) dir = DIR_RIGHT;
    end

    always_comb begin
        hold_nxt = hold_cnt;
        fire     = 1'b0;
        if (bus.tick) begin
            if (dir == DIR_NONE) begin
                hold_nxt = '0;
            end else if (dir != dir_prev) begin
                hold_nxt = '0;
                fire     = 1'b1;
            end else if (hold_cnt == HC_W'(REPEAT_DELAY - 1)) begin
                hold_nxt = HC_W'(REPEAT_DELAY - REPEAT_RATE);
                fire     = 1'b1;
            end else begin
                hold_nxt = hold_cnt + HC_W'(1);
            end
        end
    end

    always_comb begin
        t_col = int'(col_q);
        t_row = int'(row_q);
        case (dir)
            DIR_UP:    t_row = t_row - 1;
            DIR_DOWN:  t_row = t_row + 1;
            DIR_LEFT:  t_col = t_col - 1;
            DIR_RIGHT: t_col = t_col + 1;
            default:   ;
        endcase
        in_grid = (t_col >= 0) && (t_col < COLS) && (t_row >= 0) && (t_row < ROWS);
    end

    // Pixel target of the committed cell; only one axis differs during a step.
    always_comb begin
        tx     = X_W'(X0 + int'(col_q) * CELL);
        ty     = Y_W'(Y0 + int'(row_q) * CELL);
        x_step = x_q;
        y_step = y_q;
        if (x_q < tx)      x_step = x_q + STEP_X;
        else if (x_q > tx) x_step = x_q - STEP_X;
        else if (y_q < ty) y_step = y_q + STEP_Y;
        else if (y_q > ty) y_step = y_q - STEP_Y;
        arrive = (x_step == tx) && (y_step == ty);
    end

    // A request on the arrival edge is judged from the freshly reached cell,
    // so a held key keeps its repeat cadence across consecutive steps.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        do_bump = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE: begin
                if (fire && bus.enable) begin
                    if (in_grid) begin
                        accept  = 1'b1;
                        state_d = MOVE;
                    end else begin
                        do_bump = 1'b1;
                    end
                end
            end
            MOVE: begin
                if (bus.tick) begin
                    advance = 1'b1;
                    if (arrive) begin
                        state_d = IDLE;
                        if (fire && bus.enable) begin
                            if (in_grid) begin
                                accept  = 1'b1;
                                state_d = MOVE;
                            end else begin
                                do_bump = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dir_prev <= DIR_NONE;
            hold_cnt <= '0;
            col_q    <= COL_RST;
            row_q    <= ROW_RST;
            x_q      <= X_RST;
            y_q      <= Y_RST;
            bump_q   <= 1'b0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_nxt;
            bump_q   <= do_bump;
            if (bus.tick) dir_prev <= dir;
            if (advance) begin
                x_q <= x_step;
                y_q <= y_step;
            end
            if (accept) begin
                col_q <= COL_W'(t_col);
                row_q <= ROW_W'(t_row);
            end
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.col    = col_q;
    assign bus.row    = row_q;
    assign bus.moving = (state == MOVE);
    assign bus.bump   = bump_q;
endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover with default parameters (5x5 grid, 16px cells).
module tb_player_mover;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    player_mover_if #(.X_W(8), .Y_W(7), .COL_W(3), .ROW_W(3)) bus ();

    player_mover dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick_once();
        @(negedge clk);
        bus.tick = 1'b1;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.up = 1'b0; bus.down = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
        bus.tick = 1'b0; bus.enable = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.x !== 8'd72) begin fails++; $display("FAIL reset_x got=%0d exp=72", bus.x); end
        tests++; if (bus.y !== 7'd52) begin fails++; $display("FAIL reset_y got=%0d exp=52", bus.y); end
        tests++; if (bus.col !== 3'd2) begin fails++; $display("FAIL reset_col got=%0d exp=2", bus.col); end
        tests++; if (bus.row !== 3'd2) begin fails++; $display("FAIL reset_row got=%0d exp=2", bus.row); end
        tests++; if (bus.moving !== 1'b0 || bus.bump !== 1'b0) begin
            fails++; $display("FAIL reset_flags got moving=%b bump=%b exp 0 0", bus.moving, bus.bump);
        end
    endtask

    task automatic test_single_step();
        logic [7:0] exp_x [4] = '{8'd76, 8'd80, 8'd84, 8'd88};
        do_reset();
        bus.right = 1'b1;
        tick_once();
        bus.right = 1'b0;
        tests++; if (bus.col !== 3'd3 || bus.moving !== 1'b1 || bus.x !== 8'd72) begin
            fails++; $display("FAIL step_commit got col=%0d mv=%b x=%0d exp col=3 mv=1 x=72", bus.col, bus.moving, bus.x);
        end
        for (int i = 0; i < 4; i++) begin
            tick_once();
            tests++; if (bus.x !== exp_x[i] || bus.moving !== (i != 3)) begin
                fails++; $display("FAIL step_x%0d got x=%0d mv=%b exp x=%0d mv=%b", i, bus.x, bus.moving, exp_x[i], (i != 3));
            end
        end
    endtask

    task automatic test_repeat_up();
        int bumps = 0;
        do_reset();
        bus.up = 1'b1;
        for (int t = 0; t <= 16; t++) begin
            tick_once();
            if (bus.bump === 1'b1) bumps++;
            tests++; if (bus.bump !== ((t == 12) || (t == 16))) begin
                fails++; $display("FAIL repeat_bump_t%0d got=%b exp=%b", t, bus.bump, ((t == 12) || (t == 16)));
            end
            if (t == 0) begin
                tests++; if (bus.row !== 3'd1 || bus.moving !== 1'b1) begin
                    fails++; $display("FAIL repeat_t0 got row=%0d mv=%b exp row=1 mv=1", bus.row, bus.moving);
                end
            end
            if (t == 4) begin
                tests++; if (bus.y !== 7'd36 || bus.moving !== 1'b0) begin
                    fails++; $display("FAIL repeat_t4 got y=%0d mv=%b exp y=36 mv=0", bus.y, bus.moving);
                end
            end
            if (t == 7) begin
                tests++; if (bus.row !== 3'd1) begin fails++; $display("FAIL repeat_t7 got row=%0d exp=1", bus.row); end
            end
            if (t == 8) begin
                tests++; if (bus.row !== 3'd0 || bus.moving !== 1'b1) begin
                    fails++; $display("FAIL repeat_t8 got row=%0d mv=%b exp row=0 mv=1", bus.row, bus.moving);
                end
            end
            if (t == 12) begin
                tests++; if (bus.y !== 7'd20 || bus.row !== 3'd0 || bus.moving !== 1'b0) begin
                    fails++; $display("FAIL repeat_t12 got y=%0d row=%0d mv=%b exp y=20 row=0 mv=0", bus.y, bus.row, bus.moving);
                end
            end
        end
        bus.up = 1'b0;
        tests++; if (bumps != 2) begin fails++; $display("FAIL repeat_bump_count got=%0d exp=2", bumps); end
    endtask

    task automatic test_cancel();
        do_reset();
        bus.left = 1'b1; bus.right = 1'b1; bus.down = 1'b1;
        tick_once();
        clear_inputs();
        tests++; if (bus.row !== 3'd3 || bus.col !== 3'd2) begin
            fails++; $display("FAIL cancel_cell got row=%0d col=%0d exp row=3 col=2", bus.row, bus.col);
        end
        repeat (4) tick_once();
        tests++; if (bus.y !== 7'd68 || bus.x !== 8'd72 || bus.moving !== 1'b0) begin
            fails++; $display("FAIL cancel_pos got y=%0d x=%0d mv=%b exp y=68 x=72 mv=0", bus.y, bus.x, bus.moving);
        end
    endtask

    task automatic test_drop_in_move();
        do_reset();
        bus.right = 1'b1;
        tick_once();
        bus.right = 1'b0;
        tick_once();
        bus.right = 1'b1;
        tick_once();
        bus.right = 1'b0;
        tests++; if (bus.x !== 8'd80 || bus.col !== 3'd3 || bus.bump !== 1'b0) begin
            fails++; $display("FAIL drop_mid got x=%0d col=%0d bump=%b exp x=80 col=3 bump=0", bus.x, bus.col, bus.bump);
        end
        repeat (2) tick_once();
        tests++; if (bus.x !== 8'd88 || bus.col !== 3'd3 || bus.moving !== 1'b0) begin
            fails++; $display("FAIL drop_end got x=%0d col=%0d mv=%b exp x=88 col=3 mv=0", bus.x, bus.col, bus.moving);
        end
    endtask

    task automatic test_enable_and_tick();
        do_reset();
        bus.enable = 1'b0; bus.left = 1'b1;
        tick_once();
        bus.left = 1'b0;
        tests++; if (bus.col !== 3'd2 || bus.moving !== 1'b0 || bus.bump !== 1'b0) begin
            fails++; $display("FAIL en_off got col=%0d mv=%b bump=%b exp col=2 mv=0 bump=0", bus.col, bus.moving, bus.bump);
        end
        tick_once();
        bus.enable = 1'b1; bus.left = 1'b1;
        tick_once();
        bus.left = 1'b0; bus.enable = 1'b0;
        tests++; if (bus.col !== 3'd1 || bus.moving !== 1'b1) begin
            fails++; $display("FAIL en_on got col=%0d mv=%b exp col=1 mv=1", bus.col, bus.moving);
        end
        repeat (4) tick_once();
        tests++; if (bus.x !== 8'd56 || bus.moving !== 1'b0) begin
            fails++; $display("FAIL en_no_abort got x=%0d mv=%b exp x=56 mv=0", bus.x, bus.moving);
        end
        bus.enable = 1'b1; bus.right = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tests++; if (bus.col !== 3'd1 || bus.x !== 8'd56 || bus.moving !== 1'b0) begin
            fails++; $display("FAIL no_tick got col=%0d x=%0d mv=%b exp col=1 x=56 mv=0", bus.col, bus.x, bus.moving);
        end
        tick_once();
        bus.right = 1'b0;
        tests++; if (bus.col !== 3'd2 || bus.moving !== 1'b1) begin
            fails++; $display("FAIL tick_fires got col=%0d mv=%b exp col=2 mv=1", bus.col, bus.moving);
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        bus.right = 1'b1;
        tick_once();
        bus.right = 1'b0;
        repeat (2) tick_once();
        tests++; if (bus.x !== 8'd80) begin fails++; $display("FAIL rmm_pre got x=%0d exp=80", bus.x); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (bus.x !== 8'd72 || bus.col !== 3'd2 || bus.moving !== 1'b0) begin
            fails++; $display("FAIL rmm_async got x=%0d col=%0d mv=%b exp x=72 col=2 mv=0", bus.x, bus.col, bus.moving);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_step();
        test_repeat_up();
        test_cancel();
        test_drop_in_move();
        test_enable_and_tick();
        test_reset_mid_move();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
